coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Front-end stage for the vending machine FSM. Conditions raw coin-slot sensors (1p, 5p):
//  2-FF sync, per-line debounce, rising-edge detect, then buffers accepted coins in a small FIFO.
//  Replays each coin as a one-cycle p1/p5 pulse, in arrival order, with a guaranteed idle gap
//  so the downstream FSM never sees back-to-back or simultaneous coin pulses.
// PARAMETERS
//  DEB_CYCLES  4  consecutive sampled cycles a synced line must differ from stable value to flip it (>=1)
//  FIFO_DEPTH  4  coin FIFO entries (power of 2, >=2); entry = 1 bit (0=1p, 1=5p)
//  GAP_CYCLES  2  minimum idle cycles between successive output pulses (>=0)
// PORTS
//  Clk         in   1                  system clock, all state on posedge
//  nrst        in   1                  asynchronous, active-high reset
//  coin1_raw   in   1                  raw 1p slot sensor, asynchronous, may bounce
//  coin5_raw   in   1                  raw 5p slot sensor, asynchronous, may bounce
//  p1          out  1                  registered 1-cycle pulse: one 1p coin delivered downstream
//  p5          out  1                  registered 1-cycle pulse: one 5p coin delivered downstream
//  reject      out  1                  registered 1-cycle pulse: >=1 coin dropped (FIFO full) this cycle
//  coin_full   out  1                  FIFO occupancy == FIFO_DEPTH
//  coin_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, nrst=1): p1=p5=reject=0, coin_count=0, coin_full=0; FIFO flushed; sync FFs,
//   stable values and debounce counters =0; FSM=IDLE. Reset mid-pulse/mid-gap aborts immediately.
//  A line already high at reset release is treated as a new coin after debounce (stable starts 0).
//  Debounce per line: if sync!=stable, cnt++; when cnt would reach DEB_CYCLES, stable<=sync, cnt<=0;
//   any cycle with sync==stable clears cnt. Glitches shorter than DEB_CYCLES are ignored entirely.
//  Coin event = rising edge of stable (stable & ~stable_d). Falling edge produces nothing; holding
//   a line high indefinitely yields exactly one coin.
//  Push: event writes FIFO on the next edge. Both lines' events in same cycle: 1p entry written
//   first, then 5p. Space judged on pre-cycle coin_count only (a same-cycle pop does NOT make room).
//   Room for one only: 1p accepted, 5p dropped. Any drop -> reject=1 for exactly one cycle.
//  Output FSM (one-hot p1/p5, never both high):
//   IDLE: FIFO non-empty -> pop head; drive p1 (head=0) or p5 (head=1) high next cycle; ->EMIT.
//   EMIT: pulse is high this cycle; next cycle pulse low; ->GAP if GAP_CYCLES>0 else ->IDLE.
//   GAP : count GAP_CYCLES cycles with outputs low, then ->IDLE.
//   => successive pulses separated by exactly GAP_CYCLES+1 low cycles when FIFO stays non-empty.
//  Latency: raw rising sampled at edge k, stable for debounce -> p1/p5 high after edge
//   k+DEB_CYCLES+3 (7 edges with defaults), FIFO empty and FSM IDLE.
//  coin_count/coin_full update on the edge of push/pop; push+pop same edge: count unchanged.
//  Pointers wrap modulo FIFO_DEPTH; coin_count never exceeds FIFO_DEPTH nor underflows.
// TESTING
//  1. Reset; coin1_raw 0->1 held 20 cycles -> single p1 pulse 7 cycles after sampling edge, p5=0, reject=0.
//  2. coin5_raw glitches high 3 cycles (DEB=4), repeated 5x -> no p5, coin_count stays 0.
//  3. coin1_raw and coin5_raw rise same cycle -> p1 pulse, 3 low cycles, then p5 pulse; no reject.
//  4. Force 6 coins in quick succession (alternating lines, 5 cycles apart) with downstream drain
//     slower -> coin_full=1 at count 4, reject pulse for each dropped coin; delivered order = accepted order.
//  5. Assert nrst during EMIT with 3 coins queued -> p1/p5 drop same cycle, coin_count=0, no pulses after release
//     until a new debounced edge.
//  6. coin5_raw bounces 1-0-1 (each 2 cycles) then stable high -> exactly one p5; falling edge -> nothing.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin-slot sensor inputs and paced coin pulse outputs of the coin acceptor front end.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          coin1_raw;
    logic                          coin5_raw;
    logic                          p1;
    logic                          p5;
    logic                          reject;
    logic                          coin_full;
    logic [$clog2(FIFO_DEPTH):0]   coin_count;

    modport master (
        output coin1_raw, coin5_raw,
        input  p1, p5, reject, coin_full, coin_count
    );

    modport slave (
        input  coin1_raw, coin5_raw,
        output p1, p5, reject, coin_full, coin_count
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin-slot front end: 2-FF sync, per-line debounce, rising-edge detect, coin FIFO, paced p1/p5 replay.
// Latency DEB_CYCLES+3 edges from sampled rise to pulse; no backpressure, coins hitting a full FIFO are dropped and flagged on reject.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           nrst,
    coin_acceptor_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    // Bit 0 carries the 1p line, bit 1 the 5p line; matches the FIFO entry encoding.
    logic [1:0]            sync1, sync2, stable, stable_d, ev;
    logic [FIFO_DEPTH-1:0] mem;
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count, room;
    logic                  acc1, acc5, drop, pop, head;
    logic                  rej_q, p1_q, p5_q, p1_nxt, p5_nxt;
    state_t                state, state_nxt;
    logic [GW-1:0]         gap_cnt, gap_cnt_nxt;

    always_ff @(posedge Clk or posedge nrst) begin
        if (nrst) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            stable_d <= 2'b00;
        end else begin
            sync1    <= {bus.coin5_raw, bus.coin1_raw};
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          st;

        always_ff @(posedge Clk or posedge nrst) begin
            if (nrst) begin
                cnt <= '0;
                st  <= 1'b0;
            end else if (sync2[i] == st) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                st  <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end

        assign stable[i] = st;
    end

    assign ev = stable & ~stable_d;

    // Room is judged on the pre-edge occupancy only; a same-edge pop never frees a slot.
    always_comb begin
        room = CW'(FIFO_DEPTH) - count;
        acc1 = ev[0] && (room != '0);
        acc5 = ev[1] && (room > CW'(acc1));
        drop = (ev[0] && !acc1) || (ev[1] && !acc5);
    end

    always_ff @(posedge Clk or posedge nrst) begin
        if (nrst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rej_q <= 1'b0;
        end else begin
            if (acc1) mem[wptr] <= 1'b0;
            if (acc5) mem[wptr + PW'(acc1)] <= 1'b1;
            wptr  <= wptr + PW'(acc1) + PW'(acc5);
            if (pop) rptr <= rptr + PW'(1);
            count <= count + CW'(acc1) + CW'(acc5) - CW'(pop);
            rej_q <= drop;
        end
    end

    assign head = mem[rptr];

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        p1_nxt      = 1'b0;
        p5_nxt      = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    p1_nxt    = ~head;
                    p5_nxt    = head;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                gap_cnt_nxt = '0;
                state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge nrst) begin
        if (nrst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            p1_q    <= 1'b0;
            p5_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            p1_q    <= p1_nxt;
            p5_q    <= p5_nxt;
        end
    end

    assign bus.p1         = p1_q;
    assign bus.p5         = p5_q;
    assign bus.reject     = rej_q;
    assign bus.coin_count = count;
    assign bus.coin_full  = (count == CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: a default instance plus a slow-drain instance share the coin lines,
// both compared every cycle against a queue-level reference model, with scenario checks per task.
`timescale 1ns/1ps
module tb_coin_acceptor;
    localparam int DEB  = 4;
    localparam int FD   = 4;
    localparam int CW   = 3;
    localparam int GAP0 = 2;
    localparam int GAP1 = 30;

    logic Clk = 1'b0;
    logic nrst;
    logic c1, c5;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 Clk = ~Clk;

    coin_acceptor_if #(.FIFO_DEPTH(FD)) bus0 ();
    coin_acceptor_if #(.FIFO_DEPTH(FD)) bus1 ();

    assign bus0.coin1_raw = c1;
    assign bus0.coin5_raw = c5;
    assign bus1.coin1_raw = c1;
    assign bus1.coin5_raw = c5;

    coin_acceptor #(.DEB_CYCLES(DEB), .FIFO_DEPTH(FD), .GAP_CYCLES(GAP0)) u_dut (
        .Clk(Clk), .nrst(nrst), .bus(bus0));
    coin_acceptor #(.DEB_CYCLES(DEB), .FIFO_DEPTH(FD), .GAP_CYCLES(GAP1)) u_slow (
        .Clk(Clk), .nrst(nrst), .bus(bus1));

    logic [6:0] obs [2];
    assign obs[0] = {bus0.p1, bus0.p5, bus0.reject, bus0.coin_full, bus0.coin_count};
    assign obs[1] = {bus1.p1, bus1.p5, bus1.reject, bus1.coin_full, bus1.coin_count};

    // Reference model: per-line sync/debounce, FIFO as a shift list, pulse spacing as a cooldown.
    bit m_s1[2], m_s2[2], m_st[2], m_std[2];
    int m_cnt[2];
    bit m_fifo[2][FD];
    int m_n[2], m_cool[2], m_drops[2];
    bit m_p1[2], m_p5[2], m_rej[2];
    int m_acc1[$];
    bit t_ev[2], t_raw[2], t_pop, t_head;
    int t_room;

    function automatic int gap_of(int d);
        return (d == 0) ? GAP0 : GAP1;
    endfunction

    function automatic logic [6:0] expv(int d);
        return {m_p1[d], m_p5[d], m_rej[d], m_n[d] == FD, CW'(m_n[d])};
    endfunction

    always @(posedge Clk or posedge nrst) begin
        if (nrst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_std[i] = 0; m_cnt[i] = 0;
                m_n[i] = 0; m_cool[i] = 0; m_p1[i] = 0; m_p5[i] = 0; m_rej[i] = 0;
            end
        end else begin
            t_raw[0] = c1;
            t_raw[1] = c5;
            for (int l = 0; l < 2; l++) t_ev[l] = m_st[l] && !m_std[l];
            for (int d = 0; d < 2; d++) begin
                t_room = FD - m_n[d];
                t_pop  = (m_cool[d] == 0) && (m_n[d] > 0);
                t_head = m_fifo[d][0];
                if (t_pop) begin
                    for (int k = 0; k < FD - 1; k++) m_fifo[d][k] = m_fifo[d][k+1];
                    m_n[d]--;
                end
                m_rej[d] = 0;
                for (int l = 0; l < 2; l++) begin
                    if (t_ev[l]) begin
                        if (t_room > 0) begin
                            m_fifo[d][m_n[d]] = (l == 1);
                            m_n[d]++;
                            t_room--;
                            if (d == 1) m_acc1.push_back(l);
                        end else begin
                            m_rej[d] = 1;
                            m_drops[d]++;
                        end
                    end
                end
                if (t_pop) m_cool[d] = gap_of(d) + 1;
                else if (m_cool[d] > 0) m_cool[d]--;
                m_p1[d] = t_pop && !t_head;
                m_p5[d] = t_pop && t_head;
            end
            for (int l = 0; l < 2; l++) begin
                m_std[l] = m_st[l];
                if (m_s2[l] != m_st[l]) begin
                    if (m_cnt[l] + 1 == DEB) begin
                        m_st[l]  = m_s2[l];
                        m_cnt[l] = 0;
                    end else begin
                        m_cnt[l]++;
                    end
                end else begin
                    m_cnt[l] = 0;
                end
                m_s2[l] = m_s1[l];
                m_s1[l] = t_raw[l];
            end
        end
    end

    task automatic step(input bit r1, input bit r5);
        c1 = r1;
        c5 = r5;
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        c1 = 0; c5 = 0; nrst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 7'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %b want 0000000", d, obs[d]);
            end
        end
        nrst = 1'b0;
        repeat (4) begin
            step(0, 0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL reset_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
        end
    endtask

    task automatic test_single_coin;
        int rise, p1_at, np1, np5, nrej;
        p1_at = -1; np1 = 0; np5 = 0; nrej = 0;
        step(1, 0);
        rise = cyc;
        for (int t = 0; t < 40; t++) begin
            if (t < 19) step(1, 0); else step(0, 0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL single_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
            if (bus0.p1 === 1'b1 && p1_at < 0) p1_at = cyc;
            np1 += int'(bus0.p1); np5 += int'(bus0.p5); nrej += int'(bus0.reject);
        end
        checks++;
        if (p1_at - rise !== DEB + 3) begin
            errors++;
            $display("FAIL single_latency: got %0d want %0d", p1_at - rise, DEB + 3);
        end
        checks++;
        if (np1 !== 1 || np5 !== 0 || nrej !== 0) begin
            errors++;
            $display("FAIL single_pulses: p1=%0d p5=%0d rej=%0d want 1 0 0", np1, np5, nrej);
        end
    endtask

    task automatic test_glitch;
        int np5, maxcnt;
        np5 = 0; maxcnt = 0;
        for (int g = 0; g < 5; g++) begin
            for (int t = 0; t < 9; t++) begin
                step(0, t < DEB - 1);
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs[d] !== expv(d)) begin
                        errors++;
                        $display("FAIL glitch_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                    end
                end
                np5 += int'(bus0.p5);
                if (int'(bus0.coin_count) > maxcnt) maxcnt = int'(bus0.coin_count);
            end
        end
        checks++;
        if (np5 !== 0 || maxcnt !== 0) begin
            errors++;
            $display("FAIL glitch_ignored: p5=%0d max_count=%0d want 0 0", np5, maxcnt);
        end
    endtask

    task automatic test_simultaneous;
        int p1_at, p5_at, np1, np5, nrej;
        p1_at = -1; p5_at = -1; np1 = 0; np5 = 0; nrej = 0;
        for (int t = 0; t < 36; t++) begin
            step(t < 12, t < 12);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL simul_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
            if (bus0.p1 === 1'b1 && p1_at < 0) p1_at = cyc;
            if (bus0.p5 === 1'b1 && p5_at < 0) p5_at = cyc;
            np1 += int'(bus0.p1); np5 += int'(bus0.p5); nrej += int'(bus0.reject);
        end
        checks++;
        if (p1_at < 0 || p5_at - p1_at !== GAP0 + 2) begin
            errors++;
            $display("FAIL simul_order: p1 at %0d p5 at %0d want p5 %0d edges after p1", p1_at, p5_at, GAP0 + 2);
        end
        checks++;
        if (np1 !== 1 || np5 !== 1 || nrej !== 0) begin
            errors++;
            $display("FAIL simul_pulses: p1=%0d p5=%0d rej=%0d want 1 1 0", np1, np5, nrej);
        end
    endtask

    task automatic test_overflow;
        int guard, nrej, drops0, got[$];
        bit seen_full;
        guard = 0; nrej = 0; seen_full = 0;
        while ((m_n[1] != 0 || m_cool[1] != 0) && guard < 200) begin
            step(0, 0);
            guard++;
        end
        m_acc1.delete();
        drops0 = m_drops[1];
        guard = 0;
        for (int t = 0; t < 400 && (t < 40 || m_n[1] != 0 || m_cool[1] != 0); t++) begin
            guard = t + 1;
            if (t < 30) step(((t / 5) % 2) == 0, ((t / 5) % 2) == 1);
            else step(0, 0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL ovf_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
            if (bus1.coin_full === 1'b1 && bus1.coin_count === 3'd4) seen_full = 1;
            if (bus1.p1 === 1'b1) got.push_back(0);
            if (bus1.p5 === 1'b1) got.push_back(1);
            nrej += int'(bus1.reject);
        end
        checks++;
        if (guard >= 400) begin
            errors++;
            $display("FAIL ovf_drain_timeout: count=%0d want 0 within 400 cycles", bus1.coin_count);
        end
        checks++;
        if (seen_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: coin_full at count 4 seen=%0d want 1", seen_full);
        end
        checks++;
        if (nrej !== m_drops[1] - drops0 || nrej < 1) begin
            errors++;
            $display("FAIL ovf_reject: got %0d reject pulses want %0d (>=1)", nrej, m_drops[1] - drops0);
        end
        checks++;
        if (got.size() !== m_acc1.size()) begin
            errors++;
            $display("FAIL ovf_count: delivered %0d coins want %0d", got.size(), m_acc1.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== m_acc1[i]) begin
                    errors++;
                    $display("FAIL ovf_order idx%0d: got %0d want %0d", i, got[i], m_acc1[i]);
                end
            end
        end
    endtask

    task automatic test_reset_emit;
        bit found;
        int npulse;
        found = 0; npulse = 0;
        for (int t = 0; t < 400 && !found; t++) begin
            step((t % 10) < 5, (t % 10) < 5);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL rst_emit_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
            found = (m_p1[1] || m_p5[1]) && (m_n[1] == 3);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_emit_setup: no pulse with 3 queued within 400 cycles, count=%0d", bus1.coin_count);
        end
        c1 = 0; c5 = 0;
        nrst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 7'd0) begin
                errors++;
                $display("FAIL rst_emit_abort inst%0d: got %b want 0000000", d, obs[d]);
            end
        end
        step(0, 0);
        nrst = 1'b0;
        for (int t = 0; t < 30; t++) begin
            step(0, 0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL rst_emit_after inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
            npulse += int'(bus0.p1) + int'(bus0.p5) + int'(bus1.p1) + int'(bus1.p5);
        end
        checks++;
        if (npulse !== 0) begin
            errors++;
            $display("FAIL rst_emit_quiet: got %0d pulses after release want 0", npulse);
        end
    endtask

    task automatic test_bounce;
        bit pat [6];
        int np1, np5;
        pat = '{1, 1, 0, 0, 1, 1};
        np1 = 0; np5 = 0;
        for (int t = 0; t < 50; t++) begin
            if (t < 6) step(0, pat[t]);
            else step(0, t < 20);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) begin
                    errors++;
                    $display("FAIL bounce_model inst%0d cyc%0d: got %b want %b", d, cyc, obs[d], expv(d));
                end
            end
            np1 += int'(bus0.p1); np5 += int'(bus0.p5);
        end
        checks++;
        if (np5 !== 1 || np1 !== 0) begin
            errors++;
            $display("FAIL bounce_pulses: p5=%0d p1=%0d want 1 0", np5, np1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) m_drops[d] = 0;
        test_reset();
        test_single_coin();
        test_glitch();
        test_simultaneous();
        test_overflow();
        test_reset_emit();
        test_bounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation stalled at cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
